// File: rtl/con_pkg.sv
// con_pkg: shared definitions for the CON run/start/step control.
//   diag_fn_e      : console diag control function codes carried on DS
//   RB_*           : DIAG_SEL readback select codes
package con_pkg;

    typedef enum logic [2:0] {
        FN_CLR_RUN     = 3'd0,
        FN_SET_RUN     = 3'd1,
        FN_CONTINUE    = 3'd2,
        FN_LOAD_STEP   = 3'd3,
        FN_IR_STROBE   = 3'd4,
        FN_DRAM_STROBE = 3'd5
    } diag_fn_e;

    localparam logic [2:0] RB_RUN0     = 3'd0;
    localparam logic [2:0] RB_RUN      = 3'd1;
    localparam logic [2:0] RB_START    = 3'd2;
    localparam logic [2:0] RB_INSTR_GO = 3'd3;
    localparam logic [2:0] RB_STEP_NZ  = 3'd4;
    localparam logic [2:0] RB_HALTED   = 3'd5;
    localparam logic [2:0] RB_STATE_LO = 3'd6;
    localparam logic [2:0] RB_STATE_HI = 3'd7;

endpackage

// File: rtl/con_sync_pipe.sv
// con_sync_pipe: DEPTH-stage flop chain with asynchronous active-high reset.
//   clk, rst : clock, async reset (clears every stage)
//   d        : pipeline input
//   q        : output, d delayed DEPTH edges
//   q_nxt    : value q takes at the next edge (lets the source see its own
//              change arriving at the output one cycle ahead)
module con_sync_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic q_nxt
);

    logic [DEPTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d[0] = d;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
    end

    assign q     = pipe_q[DEPTH-1];
    assign q_nxt = pipe_d[DEPTH-1];

endmodule

// File: rtl/con_runctl.sv
// con_runctl: EBOX run/start/step control for the CON board.
// Decodes console diag control functions (DS when DIAG_CTL_FUNC_01x=1) into
// run/continue requests, delays them to RUN/START through SYNC_DEPTH-stage
// pipes, holds INSTR_GO and the microcode state flags, and offers a diag
// readback bit.
// Optional feature, macro CON_STEP_EN: instruction-step counter (LOAD_STEP,
// STEP_DONE, DIAG_SEL=4). Without it DS=011 is a no-op and STEP_DONE=0.
// Ports:
//   clk, RESET                 : clock, async active-high reset
//   DIAG_CTL_FUNC_01x, DS      : diag function strobe and select
//   STEP_DATA, NICOND          : step count load value, instruction boundary
//   GO_HOLD                    : INSTR_GO hold term
//   COND_EBOX_STATE, MAGIC     : state flag update enable and {set,hold} pairs
//   EBOX_HALTED                : halted flag
//   DIAG_READ, DIAG_SEL        : readback enable/select -> DIAG_Q
//   RUN, START, INSTR_GO       : run/start/continue outputs
//   IR_STROBE, DRAM_STROBE     : combinational strobe decodes
//   UCODE_STATE, STEP_DONE     : state flags, step expiry pulse
//   PI_DISABLE                 : ~RUN | EBOX_HALTED
module con_runctl
    import con_pkg::*;
#(
    parameter int SYNC_DEPTH = 3,
    parameter int NSTATE     = 4,
    parameter int STEP_W     = 8
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  DIAG_CTL_FUNC_01x,
    input  logic [2:0]            DS,
    input  logic [STEP_W-1:0]     STEP_DATA,
    input  logic                  NICOND,
    input  logic                  GO_HOLD,
    input  logic                  COND_EBOX_STATE,
    input  logic [2*NSTATE-1:0]   MAGIC,
    input  logic                  EBOX_HALTED,
    input  logic                  DIAG_READ,
    input  logic [2:0]            DIAG_SEL,
    output logic                  RUN,
    output logic                  START,
    output logic                  INSTR_GO,
    output logic                  IR_STROBE,
    output logic                  DRAM_STROBE,
    output logic [NSTATE-1:0]     UCODE_STATE,
    output logic                  STEP_DONE,
    output logic                  PI_DISABLE,
    output logic                  DIAG_Q
);

    diag_fn_e fn_code;
    logic     fn_clr, fn_set, fn_cont;

    assign fn_code     = diag_fn_e'(DS);
    assign fn_clr      = DIAG_CTL_FUNC_01x && (fn_code == FN_CLR_RUN);
    assign fn_set      = DIAG_CTL_FUNC_01x && (fn_code == FN_SET_RUN);
    assign fn_cont     = DIAG_CTL_FUNC_01x && (fn_code == FN_CONTINUE);
    assign IR_STROBE   = DIAG_CTL_FUNC_01x && (fn_code == FN_IR_STROBE);
    assign DRAM_STROBE = DIAG_CTL_FUNC_01x && (fn_code == FN_DRAM_STROBE);

    logic              run0_q, run0_d;
    logic              start0_q, start0_d;
    logic              go_q, go_d;
    logic [NSTATE-1:0] flags_q, flags_d;
    logic              start_nxt, run_nxt_unused;
    logic              step_expire, cnt_nz;

`ifdef CON_STEP_EN
    logic              fn_load;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              step_done_q, step_done_d;

    assign fn_load = DIAG_CTL_FUNC_01x && (fn_code == FN_LOAD_STEP);

    // A load overrides a same-cycle decrement. Only the visible RUN (not
    // run0) qualifies NICOND, so boundaries in flight are not counted.
    always_comb begin
        cnt_d       = cnt_q;
        step_expire = 1'b0;
        if (fn_load) begin
            cnt_d = STEP_DATA;
        end else if ((cnt_q != '0) && RUN && NICOND) begin
            cnt_d       = cnt_q - STEP_W'(1);
            step_expire = (cnt_q == STEP_W'(1));
        end
        step_done_d = step_expire;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cnt_q       <= '0;
            step_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            step_done_q <= step_done_d;
        end
    end

    assign STEP_DONE = step_done_q;
    assign cnt_nz    = |cnt_q;
`else
    logic unused_step;
    assign unused_step = ^{STEP_DATA, NICOND};
    assign step_expire = 1'b0;
    assign STEP_DONE   = 1'b0;
    assign cnt_nz      = 1'b0;
`endif

    always_comb begin
        run0_d = run0_q;
        if (fn_set) run0_d = 1'b1;
        if (fn_clr || step_expire) run0_d = 1'b0;
        // start0 drops on the edge its value reaches START; a CONTINUE that
        // arrives while it is still set merges into the pending pulse.
        start0_d = start0_q ? !start_nxt : fn_cont;
        go_d     = fn_cont || (go_q && GO_HOLD);
        flags_d  = flags_q;
        if (COND_EBOX_STATE) begin
            for (int k = 0; k < NSTATE; k++)
                flags_d[k] = MAGIC[2*k] || (MAGIC[2*k+1] && flags_q[k]);
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            run0_q   <= 1'b0;
            start0_q <= 1'b0;
            go_q     <= 1'b0;
            flags_q  <= '0;
        end else begin
            run0_q   <= run0_d;
            start0_q <= start0_d;
            go_q     <= go_d;
            flags_q  <= flags_d;
        end
    end

    con_sync_pipe #(.DEPTH(SYNC_DEPTH)) u_run_pipe (
        .clk   (clk),
        .rst   (RESET),
        .d     (run0_q),
        .q     (RUN),
        .q_nxt (run_nxt_unused)
    );

    con_sync_pipe #(.DEPTH(SYNC_DEPTH)) u_start_pipe (
        .clk   (clk),
        .rst   (RESET),
        .d     (start0_q),
        .q     (START),
        .q_nxt (start_nxt)
    );

    assign INSTR_GO    = go_q;
    assign UCODE_STATE = flags_q;
    assign PI_DISABLE  = !RUN || EBOX_HALTED;

    logic diag_bit;
    always_comb begin
        diag_bit = 1'b0;
        case (DIAG_SEL)
            RB_RUN0:     diag_bit = run0_q;
            RB_RUN:      diag_bit = RUN;
            RB_START:    diag_bit = START;
            RB_INSTR_GO: diag_bit = go_q;
            RB_STEP_NZ:  diag_bit = cnt_nz;
            RB_HALTED:   diag_bit = EBOX_HALTED;
            RB_STATE_LO: diag_bit = flags_q[0];
            RB_STATE_HI: diag_bit = flags_q[NSTATE-1];
            default:     diag_bit = 1'b0;
        endcase
    end

    assign DIAG_Q = DIAG_READ && diag_bit;

endmodule

// File: tb/tb_con_runctl.sv
module tb_con_runctl;
    localparam int D      = 3;
    localparam int NSTATE = 4;
    localparam int STEP_W = 8;
    localparam int HMAX   = 4096;

    logic clk = 1'b0;
    logic RESET, DIAG_CTL_FUNC_01x, NICOND, GO_HOLD, COND_EBOX_STATE;
    logic EBOX_HALTED, DIAG_READ;
    logic [2:0] DS, DIAG_SEL;
    logic [STEP_W-1:0] STEP_DATA;
    logic [2*NSTATE-1:0] MAGIC;
    logic RUN, START, INSTR_GO, IR_STROBE, DRAM_STROBE, STEP_DONE, PI_DISABLE, DIAG_Q;
    logic [NSTATE-1:0] UCODE_STATE;

    int checks = 0;
    int failures = 0;

    con_runctl #(.SYNC_DEPTH(D), .NSTATE(NSTATE), .STEP_W(STEP_W)) dut (
        .clk(clk), .RESET(RESET), .DIAG_CTL_FUNC_01x(DIAG_CTL_FUNC_01x), .DS(DS),
        .STEP_DATA(STEP_DATA), .NICOND(NICOND), .GO_HOLD(GO_HOLD),
        .COND_EBOX_STATE(COND_EBOX_STATE), .MAGIC(MAGIC), .EBOX_HALTED(EBOX_HALTED),
        .DIAG_READ(DIAG_READ), .DIAG_SEL(DIAG_SEL), .RUN(RUN), .START(START),
        .INSTR_GO(INSTR_GO), .IR_STROBE(IR_STROBE), .DRAM_STROBE(DRAM_STROBE),
        .UCODE_STATE(UCODE_STATE), .STEP_DONE(STEP_DONE), .PI_DISABLE(PI_DISABLE),
        .DIAG_Q(DIAG_Q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // run0/start0 are recorded per edge; RUN/START are simply those histories
    // seen D edges later, blanked if a reset fell inside the window.
    int  cyc = 0;
    int  rst_last = 0;
    bit  run0_h [HMAX];
    bit  start0_h [HMAX];
    bit  m_run0, m_start0, m_go, m_done, m_exp;
    bit  m_clr, m_set, m_cont, m_load, m_rn;
    int  m_cnt;
    logic [NSTATE-1:0] m_flags;

    function automatic bit run_at(int n);
        if (n - D > rst_last && n - D >= 0) return run0_h[n - D];
        return 1'b0;
    endfunction

    function automatic bit start_at(int n);
        if (n - D > rst_last && n - D >= 0) return start0_h[n - D];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (RESET) begin
            m_run0 = 0; m_start0 = 0; m_go = 0; m_done = 0; m_cnt = 0; m_flags = '0;
            rst_last = cyc;
        end else begin
            m_clr  = DIAG_CTL_FUNC_01x && DS == 3'b000;
            m_set  = DIAG_CTL_FUNC_01x && DS == 3'b001;
            m_cont = DIAG_CTL_FUNC_01x && DS == 3'b010;
            m_load = DIAG_CTL_FUNC_01x && DS == 3'b011;
            m_rn   = run_at(cyc - 1);
            m_exp  = 0;
`ifdef CON_STEP_EN
            if (m_load) m_cnt = int'(STEP_DATA);
            else if (m_cnt > 0 && m_rn && NICOND) begin
                m_cnt = m_cnt - 1;
                m_exp = (m_cnt == 0);
            end
`endif
            if (m_clr || m_exp) m_run0 = 0;
            else if (m_set) m_run0 = 1;
            if (m_start0) begin
                if (start_at(cyc)) m_start0 = 0;
            end else m_start0 = m_cont;
            m_go   = m_cont || (m_go && GO_HOLD);
            m_done = m_exp;
            if (COND_EBOX_STATE)
                for (int k = 0; k < NSTATE; k++)
                    m_flags[k] = MAGIC[2*k] || (MAGIC[2*k+1] && m_flags[k]);
        end
        run0_h[cyc]   = m_run0;
        start0_h[cyc] = m_start0;
    end

    function automatic bit diag_exp();
        bit b;
        case (DIAG_SEL)
            3'd0: b = m_run0;
            3'd1: b = run_at(cyc);
            3'd2: b = start_at(cyc);
            3'd3: b = m_go;
            3'd4: b = (m_cnt != 0);
            3'd5: b = EBOX_HALTED;
            3'd6: b = m_flags[0];
            default: b = m_flags[NSTATE-1];
        endcase
        return DIAG_READ && b;
    endfunction

    // compare every cycle, shortly after the active edge
    logic [11:0] act_v, exp_v;
    always @(posedge clk) begin
        #1;
        act_v = {RUN, START, INSTR_GO, IR_STROBE, DRAM_STROBE, UCODE_STATE,
                 STEP_DONE, PI_DISABLE, DIAG_Q};
        exp_v = {run_at(cyc), start_at(cyc), m_go,
                 DIAG_CTL_FUNC_01x && DS == 3'b100, DIAG_CTL_FUNC_01x && DS == 3'b101,
                 m_flags, m_done, !run_at(cyc) || EBOX_HALTED, diag_exp()};
        chk("model_cmp", 32'(act_v), 32'(exp_v));
    end

    // ---------------- directed stimulus ----------------
    // Called at a negedge; the function is sampled at the next posedge and the
    // task returns at the negedge after it.
    task automatic do_fn(input logic [2:0] ds, input logic [STEP_W-1:0] data);
        DIAG_CTL_FUNC_01x = 1'b1; DS = ds; STEP_DATA = data;
        @(negedge clk);
        DIAG_CTL_FUNC_01x = 1'b0; DS = 3'b110;
    endtask

    task automatic pulse_nicond();
        NICOND = 1'b1; @(negedge clk); NICOND = 1'b0; @(negedge clk);
    endtask

    initial begin
        RESET = 1'b1; DIAG_CTL_FUNC_01x = 0; DS = 3'b110; STEP_DATA = '0; NICOND = 0;
        GO_HOLD = 0; COND_EBOX_STATE = 0; MAGIC = '0; EBOX_HALTED = 0;
        DIAG_READ = 0; DIAG_SEL = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_pi", 32'(PI_DISABLE), 1);
        chk("rst_run", 32'(RUN), 0);
        chk("rst_diag_off", 32'(DIAG_Q), 0);
        DIAG_READ = 1; DIAG_SEL = 3'd5; EBOX_HALTED = 1;
        #1 chk("rst_diag_halt", 32'(DIAG_Q), 1);
        EBOX_HALTED = 0; DIAG_SEL = 3'd0;
        RESET = 1'b0;
        @(negedge clk);

        // SET_RUN: RUN follows run0 by D edges
        do_fn(3'b001, 0);
        chk("run0_set", 32'(DIAG_Q), 1);
        chk("run_lat0", 32'(RUN), 0);
        repeat (2) @(negedge clk);
        chk("run_lat2", 32'(RUN), 0);
        @(negedge clk);
        chk("run_rise", 32'(RUN), 1);
        chk("pi_run", 32'(PI_DISABLE), 0);

        // CLR_RUN
        do_fn(3'b000, 0);
        repeat (2) @(negedge clk);
        chk("run_hold", 32'(RUN), 1);
        @(negedge clk);
        chk("run_fall", 32'(RUN), 0);

        // CONTINUE, second CONTINUE absorbed
        do_fn(3'b010, 0);
        chk("go_rise", 32'(INSTR_GO), 1);
        chk("start_lat0", 32'(START), 0);
        @(negedge clk);
        chk("go_drop", 32'(INSTR_GO), 0);
        do_fn(3'b010, 0);
        chk("start_lat2", 32'(START), 0);
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk("start_high", 32'(START), 1);
        end
        @(negedge clk);
        chk("start_fall", 32'(START), 0);
        @(negedge clk);
        chk("start_no_extra", 32'(START), 0);

        // INSTR_GO hold
        GO_HOLD = 1;
        do_fn(3'b010, 0);
        repeat (3) @(negedge clk);
        chk("go_hold", 32'(INSTR_GO), 1);
        GO_HOLD = 0;
        @(negedge clk);
        chk("go_clear", 32'(INSTR_GO), 0);
        repeat (6) @(negedge clk);

        // strobe decodes
        DIAG_CTL_FUNC_01x = 1; DS = 3'b100;
        #1 chk("ir_strobe", 32'({IR_STROBE, DRAM_STROBE}), 2);
        DS = 3'b101;
        #1 chk("dram_strobe", 32'({IR_STROBE, DRAM_STROBE}), 1);
        DS = 3'b111;
        #1 chk("noop_strobe", 32'({IR_STROBE, DRAM_STROBE}), 0);
        @(negedge clk);
        DIAG_CTL_FUNC_01x = 0; DS = 3'b110;
        @(negedge clk);

`ifdef CON_STEP_EN
        // NICOND ignored while RUN=0 with run0=1
        do_fn(3'b011, 1);
        do_fn(3'b001, 0);
        NICOND = 1; @(negedge clk); NICOND = 0;
        DIAG_SEL = 3'd4;
        #1 chk("nicond_ignored", 32'(DIAG_Q), 1);
        repeat (2) @(negedge clk);
        chk("step_run_on", 32'(RUN), 1);
        // count 3 -> 0
        do_fn(3'b011, 3);
        pulse_nicond();
        pulse_nicond();
        chk("cnt_nz", 32'(DIAG_Q), 1);
        NICOND = 1; @(negedge clk); NICOND = 0;
        chk("step_done", 32'(STEP_DONE), 1);
        chk("cnt_zero", 32'(DIAG_Q), 0);
        @(negedge clk);
        chk("step_done_1cyc", 32'(STEP_DONE), 0);
        @(negedge clk);
        chk("step_run_hold", 32'(RUN), 1);
        @(negedge clk);
        chk("step_run_fall", 32'(RUN), 0);
        pulse_nicond();
        chk("step_no_wrap", 32'({STEP_DONE, DIAG_Q}), 0);
        // load coincident with NICOND at count 1
        do_fn(3'b001, 0);
        repeat (3) @(negedge clk);
        do_fn(3'b011, 2);
        pulse_nicond();
        NICOND = 1;
        do_fn(3'b011, 5);
        NICOND = 0;
        chk("coin_no_done", 32'(STEP_DONE), 0);
        chk("coin_cnt_nz", 32'(DIAG_Q), 1);
        for (int i = 0; i < 4; i++) pulse_nicond();
        chk("coin_run", 32'({RUN, STEP_DONE}), 2);
        NICOND = 1; @(negedge clk); NICOND = 0;
        chk("coin_cnt5_done", 32'(STEP_DONE), 1);
        repeat (4) @(negedge clk);
        chk("coin_run_fall", 32'(RUN), 0);
`else
        do_fn(3'b001, 0);
        repeat (3) @(negedge clk);
        do_fn(3'b011, 3);
        for (int i = 0; i < 4; i++) pulse_nicond();
        DIAG_SEL = 3'd4;
        #1 chk("nostep_run", 32'({RUN, STEP_DONE, DIAG_Q}), 4);
        @(negedge clk);
        do_fn(3'b000, 0);
        repeat (4) @(negedge clk);
        chk("nostep_clr", 32'(RUN), 0);
`endif

        // state flags
        COND_EBOX_STATE = 1; MAGIC = 8'b0000_0001;
        @(negedge clk); chk("flag_set", 32'(UCODE_STATE[0]), 1);
        MAGIC = 8'b0000_0010;
        @(negedge clk); chk("flag_hold", 32'(UCODE_STATE[0]), 1);
        MAGIC = 8'b0000_0000;
        @(negedge clk); chk("flag_clr", 32'(UCODE_STATE[0]), 0);
        COND_EBOX_STATE = 0; MAGIC = 8'b0000_0001;
        @(negedge clk); chk("flag_nocond", 32'(UCODE_STATE[0]), 0);
        COND_EBOX_STATE = 1; MAGIC = 8'b0100_0000;
        @(negedge clk);
        COND_EBOX_STATE = 0; MAGIC = '0; DIAG_SEL = 3'd7;
        #1 chk("flag_hi", 32'(DIAG_Q), 1);
        @(negedge clk);

        // reset while run0 is in flight
        DIAG_SEL = 3'd0;
        do_fn(3'b001, 0);
        @(negedge clk);
        RESET = 1;
        #1 chk("rst_mid_run0", 32'(DIAG_Q), 0);
        chk("rst_mid_pi", 32'(PI_DISABLE), 1);
        DIAG_READ = 0;
        #1 chk("rst_mid_diag_off", 32'(DIAG_Q), 0);
        repeat (2) @(negedge clk);
        RESET = 0; DIAG_READ = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'({RUN, START}), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end
endmodule
